// File: rtl/wr_bus_arbiter_if.sv
// Write-bus bundle: per-bridge AW/W request slices, the shared system-bus AW/W channel, grant and err.
// master = arbiter view, slave = bridges plus system bus view.
interface wr_bus_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int width = 32
);
  logic [NREQ*28-1:0]        req_awaddr;
  logic [NREQ-1:0]           req_awuser_ap;
  logic [NREQ*4-1:0]         req_awuser_id;
  logic [NREQ*4-1:0]         req_awlen;
  logic [NREQ-1:0]           req_awvalid;
  logic [NREQ-1:0]           req_awready;
  logic [NREQ*width-1:0]     req_wdata;
  logic [NREQ*(width/8)-1:0] req_wstrb;
  logic [NREQ-1:0]           req_wready;
  logic [NREQ-1:0]           req_wlast;
  logic [NREQ-1:0]           grant;
  logic [27:0]               awaddr;
  logic                      awuser_ap;
  logic [3:0]                awuser_id;
  logic [3:0]                awlen;
  logic                      awvalid;
  logic                      awready;
  logic [width-1:0]          wdata;
  logic [width/8-1:0]        wstrb;
  logic                      wready;
  logic [3:0]                wuser_id;
  logic                      wuser_last;
  logic                      err;

  modport master (
    input  req_awaddr, req_awuser_ap, req_awuser_id, req_awlen, req_awvalid,
    input  req_wdata, req_wstrb, awready, wready, wuser_id, wuser_last,
    output req_awready, req_wready, req_wlast, grant,
    output awaddr, awuser_ap, awuser_id, awlen, awvalid, wdata, wstrb, err
  );

  modport slave (
    output req_awaddr, req_awuser_ap, req_awuser_id, req_awlen, req_awvalid,
    output req_wdata, req_wstrb, awready, wready, wuser_id, wuser_last,
    input  req_awready, req_wready, req_wlast, grant,
    input  awaddr, awuser_ap, awuser_id, awlen, awvalid, wdata, wstrb, err
  );
endinterface

// File: rtl/wr_bus_arbiter.sv
// Round-robin write-bus arbiter: one bridge owns the bus from AW handshake to its matching wuser_last.
// WR_ARB_TIMEOUT_EN adds a DATA-phase watchdog that aborts a stalled burst and pulses err.
module wr_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int width   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  wr_bus_arbiter_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = width / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [3:0]      r_id, w_id_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic [PW-1:0]   w_gidx, w_sel, w_gnext;
  logic            w_sel_vld, w_match, w_beat;

`ifdef WR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   r_wdog, w_wdog_nxt;
  logic            r_err, w_err_nxt;
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  // Owner index decoded from the one-hot grant.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) w_gidx = PW'(i);
    end
  end

  assign w_gnext = PW'((int'(w_gidx) + 1) % NREQ);

  // Descending scan so the nearest requester at or after r_ptr is the last one written.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_awvalid[(int'(r_ptr) + k) % NREQ]) begin
        w_sel_vld = 1'b1;
        w_sel     = PW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_match = (bus.wuser_id == r_id);
  assign w_beat  = (r_state == DATA) && bus.wready && w_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_cnt   <= '0;
`ifdef WR_ARB_TIMEOUT_EN
      r_wdog  <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_id    <= w_id_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef WR_ARB_TIMEOUT_EN
      r_wdog  <= w_wdog_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_id_nxt    = r_id;
    w_cnt_nxt   = r_cnt;
`ifdef WR_ARB_TIMEOUT_EN
    w_wdog_nxt  = r_wdog;
    w_err_nxt   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_sel_vld) begin
          w_state_nxt = ADDR;
          w_grant_nxt = NREQ'(1) << w_sel;
        end
      end
      ADDR: begin
        // Owner withdrew before the handshake: release without moving the pointer.
        if (!bus.req_awvalid[w_gidx]) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end else if (bus.awready) begin
          w_state_nxt = DATA;
          w_id_nxt    = bus.req_awuser_id[4*int'(w_gidx) +: 4];
          w_cnt_nxt   = '0;
`ifdef WR_ARB_TIMEOUT_EN
          w_wdog_nxt  = '0;
`endif
        end
      end
      DATA: begin
        if (w_beat) begin
          w_cnt_nxt  = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
`ifdef WR_ARB_TIMEOUT_EN
          w_wdog_nxt = '0;
`endif
          if (bus.wuser_last) begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = w_gnext;
          end
        end
`ifdef WR_ARB_TIMEOUT_EN
        else if (int'(r_wdog) + 1 >= TIMEOUT) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_gnext;
          w_wdog_nxt  = '0;
          w_err_nxt   = 1'b1;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // Bus-side mux: zero outside the phase that owns each channel.
  always_comb begin
    bus.awaddr      = '0;
    bus.awuser_ap   = 1'b0;
    bus.awuser_id   = '0;
    bus.awlen       = '0;
    bus.awvalid     = 1'b0;
    bus.wdata       = '0;
    bus.wstrb       = '0;
    bus.req_awready = '0;
    bus.req_wready  = '0;
    bus.req_wlast   = '0;
    if (r_state == ADDR) begin
      bus.awaddr      = bus.req_awaddr[28*int'(w_gidx) +: 28];
      bus.awuser_ap   = bus.req_awuser_ap[w_gidx];
      bus.awuser_id   = bus.req_awuser_id[4*int'(w_gidx) +: 4];
      bus.awlen       = bus.req_awlen[4*int'(w_gidx) +: 4];
      bus.awvalid     = bus.req_awvalid[w_gidx];
      bus.req_awready = r_grant & {NREQ{bus.awready}};
    end
    if (r_state == DATA) begin
      bus.wdata      = bus.req_wdata[width*int'(w_gidx) +: width];
      bus.wstrb      = bus.req_wstrb[SW*int'(w_gidx) +: SW];
      bus.req_wready = r_grant & {NREQ{w_beat}};
      bus.req_wlast  = r_grant & {NREQ{w_match & bus.wuser_last}};
    end
  end

  assign bus.grant = r_grant;
endmodule

// File: tb/tb_wr_bus_arbiter.sv
// Bench for wr_bus_arbiter: directed corner cases, then randomized rounds scored against a round-robin model.
module tb_wr_bus_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int SW   = W / 8;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wr_bus_arbiter_if #(.NREQ(NREQ), .width(W)) bus ();
  wr_bus_arbiter #(.NREQ(NREQ), .width(W), .TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         req;
    logic [27:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    logic        ap;
  } aw_t;

  aw_t         awq[$];
  logic [35:0] wq[$];

  logic [W-1:0]  d_mem [NREQ][16];
  logic [SW-1:0] s_mem [NREQ][16];
  int            bidx  [NREQ];
  bit drv_en = 0, rsp_en = 0, mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_awaddr = '0; bus.req_awuser_ap = '0; bus.req_awuser_id = '0; bus.req_awlen = '0;
    bus.req_awvalid = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.wuser_id = '0; bus.wuser_last = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [27:0] a, input logic [3:0] id,
                         input logic [3:0] len, input logic [W-1:0] d);
    bus.req_awaddr[28*i +: 28]  = a;
    bus.req_awuser_id[4*i +: 4] = id;
    bus.req_awlen[4*i +: 4]     = len;
    bus.req_awuser_ap[i]        = 1'b0;
    bus.req_wdata[W*i +: W]     = d;
    bus.req_wstrb[SW*i +: SW]   = '1;
    bus.req_awvalid[i]          = 1'b1;
  endtask

  // Requester drivers: drop awvalid after the handshake, step through burst data per accepted beat.
  logic [NREQ-1:0] d_aw_done, d_w_acc;
  always begin
    @(negedge clk);
    d_aw_done = bus.req_awvalid & bus.req_awready;
    d_w_acc   = bus.req_wready;
    @(posedge clk);
    #1;
    if (drv_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (d_aw_done[i]) bus.req_awvalid[i] = 1'b0;
        if (d_w_acc[i]) bidx[i]++;
        bus.req_wdata[W*i +: W]   = d_mem[i][bidx[i] & 15];
        bus.req_wstrb[SW*i +: SW] = s_mem[i][bidx[i] & 15];
      end
    end
  end

  // System-bus responder: random awready, then len+1 good beats mixed with idles and wrong-id beats.
  bit         rsp_busy = 0;
  logic [3:0] rsp_id, rsp_len;
  int         rsp_done;
  logic       s_aw, s_beat, s_last;
  logic [3:0] s_id, s_len;
  always begin
    @(negedge clk);
    s_aw   = bus.awvalid & bus.awready;
    s_id   = bus.awuser_id;
    s_len  = bus.awlen;
    s_beat = rsp_busy && bus.wready && (bus.wuser_id == rsp_id);
    s_last = bus.wuser_last;
    @(posedge clk);
    #1;
    if (rsp_en) begin
      if (s_aw) begin
        rsp_busy = 1; rsp_id = s_id; rsp_len = s_len; rsp_done = 0;
      end else if (s_beat) begin
        if (s_last) rsp_busy = 0;
        else rsp_done++;
      end
      if (rsp_busy) begin
        bus.awready = 1'b0;
        case ($urandom_range(0, 7))
          0: begin bus.wready = 1'b0; bus.wuser_id = 4'($urandom); bus.wuser_last = 1'b0; end
          1: begin bus.wready = 1'b1; bus.wuser_id = rsp_id + 4'd1; bus.wuser_last = 1'($urandom); end
          default: begin
            bus.wready = 1'b1; bus.wuser_id = rsp_id; bus.wuser_last = (rsp_done == int'(rsp_len));
          end
        endcase
      end else begin
        bus.awready    = 1'($urandom_range(0, 1));
        bus.wready     = 1'($urandom_range(0, 1));
        bus.wuser_id   = 4'($urandom);
        bus.wuser_last = 1'b0;
      end
    end
  end

  // Monitor: pops expected AW/W records whenever the bus shows a handshake or accepted beat.
  bit         m_busy = 0;
  int         m_req;
  logic [3:0] m_id;
  aw_t        m_e;
  logic [35:0] m_w;
  always begin
    @(negedge clk);
    if (mon_en) begin
      if (bus.awvalid) begin
        if (awq.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected actual_grant=%0h expected=none", bus.grant);
        end else begin
          chk("aw_grant", bus.grant, onehot(awq[0].req));
          chk("aw_route", bus.req_awready, bus.awready ? onehot(awq[0].req) : '0);
          if (bus.awready) begin
            m_e = awq.pop_front();
            chk("aw_addr", bus.awaddr, m_e.addr);
            chk("aw_id", bus.awuser_id, m_e.id);
            chk("aw_len", bus.awlen, m_e.len);
            chk("aw_ap", bus.awuser_ap, m_e.ap);
            m_busy = 1; m_req = m_e.req; m_id = m_e.id;
          end
        end
      end else if (m_busy && bus.wready && bus.wuser_id == m_id) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected actual=%0h expected=none", bus.wdata);
        end else begin
          m_w = wq.pop_front();
          chk("w_dat", {bus.wstrb, bus.wdata}, m_w);
          chk("w_rdy", bus.req_wready, onehot(m_req));
          chk("w_last", bus.req_wlast, bus.wuser_last ? onehot(m_req) : '0);
          if (bus.wuser_last) m_busy = 0;
        end
      end else begin
        chk("w_quiet", {bus.req_wready, bus.req_wlast}, '0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  logic [NREQ-1:0] mask, rem;
  int p, pick, ptr_m, n;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Reset must override active-looking inputs.
    bus.req_awvalid = '1; bus.awready = 1'b1; bus.wready = 1'b1; bus.wuser_last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, '0);
    chk("rst_awvalid", bus.awvalid, 1'b0);
    chk("rst_awaddr", bus.awaddr, '0);
    chk("rst_rdy", {bus.req_awready, bus.req_wready, bus.req_wlast}, '0);
    chk("rst_wdata", {bus.wstrb, bus.wdata}, '0);
    chk("rst_err", bus.err, 1'b0);
    clear_inputs();
    rst_n = 1'b1;
    tick();

    // Single burst from requester 0 with a wrong-id beat first.
    set_req(0, 28'h0000100, 4'd4, 4'd0, 32'hA5A50001);
    tick();
    chk("t1_grant", bus.grant, 4'b0001);
    chk("t1_awvalid", bus.awvalid, 1'b1);
    chk("t1_awaddr", bus.awaddr, 28'h0000100);
    chk("t1_awid", bus.awuser_id, 4'd4);
    bus.awready = 1'b1;
    #1;
    chk("t1_awready", bus.req_awready, 4'b0001);
    tick();
    bus.req_awvalid[0] = 1'b0; bus.awready = 1'b0;
    bus.wready = 1'b1; bus.wuser_id = 4'd5; bus.wuser_last = 1'b1;
    #1;
    chk("t1_aw_off", bus.awvalid, 1'b0);
    chk("t3_ignore", {bus.req_wready, bus.req_wlast}, '0);
    chk("t1_wdata", bus.wdata, 32'hA5A50001);
    tick();
    chk("t3_hold", bus.grant, 4'b0001);
    bus.wuser_id = 4'd4;
    #1;
    chk("t1_wready", bus.req_wready, 4'b0001);
    chk("t1_wlast", bus.req_wlast, 4'b0001);
    tick();
    bus.wready = 1'b0; bus.wuser_last = 1'b0;
    #1;
    chk("t1_idle", bus.grant, '0);
    chk("t1_wdata0", {bus.wstrb, bus.wdata}, '0);

    // Requester 2 withdraws in ADDR; pointer must stay so 2 beats 3 afterwards.
    set_req(2, 28'h0ABCDEF, 4'd9, 4'd0, 32'h22220000);
    tick();
    chk("t4_grant", bus.grant, 4'b0100);
    bus.req_awvalid[2] = 1'b0;
    tick();
    chk("t4_drop", bus.grant, '0);
    set_req(2, 28'h0ABCDEF, 4'd9, 4'd0, 32'h22220000);
    set_req(3, 28'h0333333, 4'd3, 4'd15, 32'h33330000);
    tick();
    chk("t4_regrant", bus.grant, 4'b0100);
    bus.awready = 1'b1;
    tick();
    bus.req_awvalid[2] = 1'b0; bus.awready = 1'b0;
    bus.wready = 1'b1; bus.wuser_id = 4'd9; bus.wuser_last = 1'b1;
    tick();
    bus.wready = 1'b0; bus.wuser_last = 1'b0;
    chk("t4_done", bus.grant, '0);
    tick();
    chk("t2_next", bus.grant, 4'b1000);
    bus.awready = 1'b1;
    tick();
    bus.req_awvalid[3] = 1'b0; bus.awready = 1'b0;

    // Reset in the middle of requester 3's burst after seven beats.
    bus.wready = 1'b1; bus.wuser_id = 4'd3;
    repeat (7) tick();
    bus.wready = 1'b0;
    #1;
    chk("t5_wdata_pre", bus.wdata, 32'h33330000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_grant", bus.grant, '0);
    chk("t5_awvalid", bus.awvalid, 1'b0);
    chk("t5_wdata", {bus.wstrb, bus.wdata}, '0);
    clear_inputs();
    rst_n = 1'b1;
    tick();
    set_req(0, 28'h1234567, 4'd1, 4'd0, 32'h0BAD0000);
    tick();
    chk("t5_req0", bus.grant, 4'b0001);
    bus.awready = 1'b1;
    tick();
    bus.req_awvalid[0] = 1'b0; bus.awready = 1'b0;
    bus.wready = 1'b1; bus.wuser_id = 4'd1; bus.wuser_last = 1'b1;
    #1;
    chk("t5_wr", bus.req_wready, 4'b0001);
    tick();
    bus.wready = 1'b0; bus.wuser_last = 1'b0;
    chk("t5_idle", bus.grant, '0);

    // Stalled DATA phase: only wrong-id beats arrive.
    set_req(1, 28'h0000666, 4'd6, 4'd0, 32'h66660000);
    tick();
    bus.awready = 1'b1;
    tick();
    bus.req_awvalid[1] = 1'b0; bus.awready = 1'b0;
    bus.wready = 1'b1; bus.wuser_id = 4'd7;
`ifdef WR_ARB_TIMEOUT_EN
    repeat (TMO - 1) tick();
    chk("t6_wait", bus.grant, 4'b0010);
    chk("t6_noerr", bus.err, 1'b0);
    tick();
    chk("t6_err", bus.err, 1'b1);
    chk("t6_abort", bus.grant, '0);
    tick();
    chk("t6_pulse", bus.err, 1'b0);
    bus.wready = 1'b0;
`else
    repeat (TMO + 4) tick();
    chk("t6_stay", bus.grant, 4'b0010);
    chk("t6_err0", bus.err, 1'b0);
    bus.wuser_id = 4'd6; bus.wuser_last = 1'b1;
    tick();
    bus.wready = 1'b0; bus.wuser_last = 1'b0;
    chk("t6_end", bus.grant, '0);
`endif

    // Randomized rounds: all requesters in a mask assert together and hold until served.
    rst_n = 1'b0;
    tick();
    clear_inputs();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NREQ; i++) bidx[i] = 0;
    ptr_m = 0;
    drv_en = 1; rsp_en = 1; mon_en = 1;
    for (int r = 0; r < 25; r++) begin
      mask = (r == 0) ? '1 : NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          bus.req_awaddr[28*i +: 28]  = 28'($urandom);
          bus.req_awuser_id[4*i +: 4] = 4'($urandom);
          bus.req_awlen[4*i +: 4]     = 4'($urandom_range(0, 3));
          bus.req_awuser_ap[i]        = 1'($urandom);
          bidx[i] = 0;
          for (int b = 0; b < 16; b++) begin
            d_mem[i][b] = $urandom;
            s_mem[i][b] = SW'($urandom);
          end
        end
      end
      rem = mask;
      p   = ptr_m;
      while (rem != '0) begin
        pick = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (pick < 0 && rem[(p + k) % NREQ]) pick = (p + k) % NREQ;
        end
        awq.push_back('{pick, bus.req_awaddr[28*pick +: 28], bus.req_awuser_id[4*pick +: 4],
                        bus.req_awlen[4*pick +: 4], bus.req_awuser_ap[pick]});
        for (int b = 0; b <= int'(bus.req_awlen[4*pick +: 4]); b++)
          wq.push_back({s_mem[pick][b], d_mem[pick][b]});
        rem[pick] = 1'b0;
        p = (pick + 1) % NREQ;
      end
      ptr_m = p;
      tick();
      bus.req_awvalid = mask;
      n = 0;
      while ((awq.size() != 0 || wq.size() != 0 || bus.req_awvalid != '0) && n < 1000) begin
        tick();
        n++;
      end
      if (n >= 1000) begin
        checks++; errors++;
        $display("FAIL round_timeout actual_pending=%0d expected=0", awq.size() + wq.size());
        awq.delete();
        wq.delete();
      end
      repeat (2) tick();
    end
    mon_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
